pipe_stage_elastic: RTL and testbench

Parametrised elastic pipeline stage register for the in-order core, succeeding the fixed-field stall/flush stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). A valid/ready handshake on each side with a two-entry skid buffer replaces the global `stall` input. This gives full throughput and a registered `in_ready`, so backpressure does not form a combinational path through the pipeline. Placed between any two pipeline stages; the payload (pc, inst, control signals, alu result, …) is packed into one `DATA_W` bus by the instantiating stage.

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/pipe_stage_elastic_sat_counter.sv | 33 +++
 rtl/pipe_stage_elastic.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: per-stage payload layouts and their packed widths,
// used by stages to size the elastic stage registers that sit between them.
package pipe_pkg;

    localparam int XLEN        = 64;
    localparam int ILEN        = 32;
    localparam int CNT_W_DFLT  = 16;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [3:0] alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
    } ctrl_sig_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } ifid_payload_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        ctrl_sig_t       ctrl;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
    } idex_payload_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        ctrl_sig_t       ctrl;
        logic [XLEN-1:0] alu_result;
    } exmem_payload_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        ctrl_sig_t       ctrl;
        logic [XLEN-1:0] wb_value;
    } memwb_payload_t;

    localparam int CTRL_W  = $bits(ctrl_sig_t);
    localparam int IFID_W  = $bits(ifid_payload_t);
    localparam int IDEX_W  = $bits(idex_payload_t);
    localparam int EXMEM_W = $bits(exmem_payload_t);
    localparam int MEMWB_W = $bits(memwb_payload_t);

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter with a multi-bit increment, async active-low reset
// and a synchronous clear.
module sat_counter #(
    parameter int CNT_W = 16,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt_d;

    // One extra bit catches the carry; any carry means we hit the ceiling.
    always_comb begin
        sum   = {1'b0, cnt} + {{(CNT_W+1-INC_W){1'b0}}, inc};
        cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready stage register with a two-entry skid buffer; in_ready
// and out_* come straight from flops so no combinational path crosses it.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = EXMEM_W,
    parameter int CNT_W  = CNT_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_drop_cnt
);

    logic              m_vld_p0;
    logic              s_vld_p0;
    logic [DATA_W-1:0] m_data_p0;
    logic [DATA_W-1:0] s_data_p0;
    logic              in_ready_p0;

    logic              m_vld_d;
    logic              s_vld_d;
    logic              m_load_in;
    logic              m_load_s;
    logic              s_load;

    logic              in_xfer;
    logic              out_xfer;
    logic [1:0]        drop_amt;
    logic [1:0]        drop_inc;
    logic              stall_inc;

    assign in_xfer   = in_valid & in_ready_p0;
    assign out_xfer  = m_vld_p0 & out_ready;

    assign in_ready  = in_ready_p0;
    assign out_valid = m_vld_p0;
    assign out_data  = m_data_p0;

    // State is {s_vld, m_vld}: 00 EMPTY, 01 ONE, 11 TWO; 10 never occurs.
    always_comb begin
        m_vld_d   = m_vld_p0;
        s_vld_d   = s_vld_p0;
        m_load_in = 1'b0;
        m_load_s  = 1'b0;
        s_load    = 1'b0;
        if (flush) begin
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else begin
            case ({s_vld_p0, m_vld_p0})
                2'b00: begin
                    if (in_xfer) begin
                        m_vld_d   = 1'b1;
                        m_load_in = 1'b1;
                    end
                end
                2'b01: begin
                    if (in_xfer && out_xfer) begin
                        m_load_in = 1'b1;
                    end else if (in_xfer) begin
                        s_vld_d = 1'b1;
                        s_load  = 1'b1;
                    end else if (out_xfer) begin
                        m_vld_d = 1'b0;
                    end
                end
                2'b11: begin
                    if (out_xfer) begin
                        s_vld_d  = 1'b0;
                        m_load_s = 1'b1;
                    end
                end
                default: begin
                    m_vld_d = m_vld_p0;
                    s_vld_d = s_vld_p0;
                end
            endcase
        end
    end

    // Storage update: valid bits, the registered ready, and both payload slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld_p0    <= 1'b0;
            s_vld_p0    <= 1'b0;
            in_ready_p0 <= 1'b1;
            m_data_p0   <= '0;
            s_data_p0   <= '0;
        end else begin
            m_vld_p0    <= m_vld_d;
            s_vld_p0    <= s_vld_d;
            in_ready_p0 <= ~s_vld_d;
            if (m_load_s) begin
                m_data_p0 <= s_data_p0;
            end else if (m_load_in) begin
                m_data_p0 <= in_data;
            end
            if (s_load) begin
                s_data_p0 <= in_data;
            end
        end
    end

    // A beat leaving on the flush cycle was delivered; one arriving was lost.
    always_comb begin
        drop_amt = {1'b0, m_vld_p0} + {1'b0, s_vld_p0}
                 - {1'b0, out_xfer} + {1'b0, in_xfer};
        drop_inc = flush ? drop_amt : 2'd0;
    end

    assign stall_inc = m_vld_p0 & ~out_ready;

    sat_counter #(
        .CNT_W (CNT_W),
        .INC_W (1)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W),
        .INC_W (2)
    ) u_flush_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (drop_inc),
        .cnt   (flush_drop_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: per-cycle vector table plus
// hand-written reset, streaming and saturation sequences.
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    localparam int DW  = EXMEM_W;
    localparam int CW  = 16;
    localparam int SDW = 8;
    localparam int SCW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_drop_cnt;

    logic           s_flush = 1'b0;
    logic           s_in_valid = 1'b0;
    logic [SDW-1:0] s_in_data = '0;
    logic           s_in_ready;
    logic           s_out_valid;
    logic [SDW-1:0] s_out_data;
    logic           s_out_ready = 1'b0;
    logic [SCW-1:0] s_stall_cnt;
    logic [SCW-1:0] s_flush_drop_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .stall_cnt      (stall_cnt),
        .flush_drop_cnt (flush_drop_cnt)
    );

    pipe_stage_elastic #(.DATA_W(SDW), .CNT_W(SCW)) dut_sat (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (s_flush),
        .in_valid       (s_in_valid),
        .in_data        (s_in_data),
        .in_ready       (s_in_ready),
        .out_valid      (s_out_valid),
        .out_data       (s_out_data),
        .out_ready      (s_out_ready),
        .stall_cnt      (s_stall_cnt),
        .flush_drop_cnt (s_flush_drop_cnt)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       fl;
        logic       ov;
        logic       chk_d;
        logic [7:0] od;
        logic       ir;
        int         st;
        int         dr;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0; s_flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // rst iv  id     ordy fl | ov chk od    ir  st dr
        // backpressure: 1 in M, 2 in S, 3 held upstream, then drained in order
        vecs[0]  = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1, 0};
        vecs[2]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 2, 0};
        vecs[3]  = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 2, 0};
        vecs[4]  = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 2, 0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2, 0};
        // flush in TWO with an input attempt
        vecs[6]  = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 0, 0};
        vecs[7]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 1, 0};
        vecs[8]  = '{1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2, 2};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2, 2};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2, 2};
        // flush in ONE: M beat delivered, incoming 0x07 dropped
        vecs[11] = '{1'b1, 1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 1'b1, 0, 0};
        vecs[12] = '{1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1};
        // flush in EMPTY with an input transfer: that beat counts as dropped
        vecs[14] = '{1'b0, 1'b1, 8'h30, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 2};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0, 2};

        // Reset taking effect mid-TWO without a clock edge
        do_reset();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_data = 'hA; out_ready = 1'b0;
        step();
        in_data = 'hB;
        step();
        in_valid = 1'b0;
        check("two_in_ready", in_ready, 1'b0);
        check("two_stall", stall_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_in_ready", in_ready, 1'b1);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_stall", stall_cnt, 0);
        check("async_rst_drop", flush_drop_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming at full rate
        do_reset();
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = DW'(i); out_ready = 1'b1;
            step();
            check($sformatf("stream_valid_%0d", i), out_valid, 1'b1);
            check($sformatf("stream_data_%0d", i), out_data, i);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", out_valid, 1'b0);
        check("stream_stall", stall_cnt, 0);
        check("stream_in_ready", in_ready, 1'b1);

        // Per-cycle vector table
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst) do_reset();
            in_valid = vecs[i].iv;
            in_data = DW'(vecs[i].id);
            out_ready = vecs[i].ordy;
            flush = vecs[i].fl;
            step();
            check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].ov);
            if (vecs[i].chk_d)
                check($sformatf("v%0d_out_data", i), out_data, vecs[i].od);
            check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].ir);
            check($sformatf("v%0d_stall_cnt", i), stall_cnt, vecs[i].st);
            check($sformatf("v%0d_drop_cnt", i), flush_drop_cnt, vecs[i].dr);
        end
        flush = 1'b0; in_valid = 1'b0;

        // Saturation with a 4-bit counter
        do_reset();
        s_in_valid = 1'b1; s_in_data = 8'h05; s_out_ready = 1'b0;
        step();
        s_in_valid = 1'b0;
        repeat (20) step();
        check("sat_stall_15", s_stall_cnt, 15);
        check("sat_out_valid", s_out_valid, 1'b1);
        check("sat_out_data", s_out_data, 8'h05);
        repeat (5) step();
        check("sat_stall_hold", s_stall_cnt, 15);
        s_out_ready = 1'b1;
        step();
        check("sat_drained", s_out_valid, 1'b0);
        check("sat_stall_after", s_stall_cnt, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
